// File: rtl/fs_if.sv
// Operand/result bundle for the fs ripple subtractor.
// The master drives the operands and borrow-in; the slave returns the result.
interface fs_if #(
  parameter int WIDTH = 1
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] diff;
  logic             bo;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c,
    input  diff, bo, out_valid
  );

  modport slave (
    input  in_valid, a, b, c,
    output diff, bo, out_valid
  );

endinterface

// File: rtl/fs.sv
// Ripple-borrow subtractor: {bo, diff} = a - b - c, built from 1-bit
// full-subtractor cells, with an optional one-cycle output register.
module fs #(
  parameter int WIDTH        = 1,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  fs_if.slave  bus
);

  logic [WIDTH:0]   borrowChain;
  logic [WIDTH-1:0] diff_d;
  logic             bo_d;

  // Ripple the borrow from the LSB cell upward, one full-subtractor per bit
  always_comb begin
    borrowChain    = '0;
    diff_d         = '0;
    borrowChain[0] = bus.c;
    for (int i = 0; i < WIDTH; i++) begin
      diff_d[i]          = bus.a[i] ^ bus.b[i] ^ borrowChain[i];
      borrowChain[i + 1] = (~bus.a[i] & bus.b[i])
                         | (~(bus.a[i] ^ bus.b[i]) & borrowChain[i]);
    end
    bo_d = borrowChain[WIDTH];
  end

  generate
    if (REGISTER_OUT) begin : gRegistered
      logic [WIDTH-1:0] diff_q;
      logic             bo_q;
      logic             valid_q;

      // Capture every cycle; out_valid alone marks the captured result as meaningful
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          diff_q  <= '0;
          bo_q    <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          diff_q  <= diff_d;
          bo_q    <= bo_d;
          valid_q <= bus.in_valid;
        end
      end

      assign bus.diff      = diff_q;
      assign bus.bo        = bo_q;
      assign bus.out_valid = valid_q;
    end else begin : gCombinational
      // Clock and reset have no role in the purely combinational variant
      logic unusedClkRst;
      assign unusedClkRst = clk & rst_n;

      assign bus.diff      = diff_d;
      assign bus.bo        = bo_d;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_fs.sv
// Self-checking bench for fs: registered 1-bit and 8-bit variants plus a
// combinational 1-bit variant, checked against an arithmetic reference.
module tb_fs;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fs_if #(.WIDTH(1)) bus1 ();
  fs_if #(.WIDTH(8)) bus8 ();
  fs_if #(.WIDTH(1)) busc ();

  fs #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  fs #(.WIDTH(8), .REGISTER_OUT(1'b1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  fs #(.WIDTH(1), .REGISTER_OUT(1'b0)) dutc (.clk(clk), .rst_n(rst_n), .bus(busc.slave));

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Unsigned a - b - c taken modulo 2^(width+1); bit width is the borrow-out
  function automatic int refSub(input int width, input int a, input int b, input int c);
    int r;
    r = a - b - c;
    if (r < 0) r = r + (1 << (width + 1));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus1.in_valid = v; bus1.a = a[0]; bus1.b = b[0]; bus1.c = c;
    bus8.in_valid = v; bus8.a = a;    bus8.b = b;    bus8.c = c;
    busc.in_valid = v; busc.a = a[0]; busc.b = b[0]; busc.c = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare both registered DUTs with the reference for the vector captured at the last edge
  task automatic checkRegistered(input string tag, input logic v, input logic [7:0] a,
                                 input logic [7:0] b, input logic c);
    int r1;
    int r8;
    r1 = refSub(1, int'(a[0]), int'(b[0]), int'(c));
    r8 = refSub(8, int'(a), int'(b), int'(c));
    checkOutput({tag, "_diff1"}, 32'(bus1.diff), 32'(r1 & 1));
    checkOutput({tag, "_bo1"},   32'(bus1.bo),   32'((r1 >> 1) & 1));
    checkOutput({tag, "_ov1"},   32'(bus1.out_valid), 32'(v));
    checkOutput({tag, "_diff8"}, 32'(bus8.diff), 32'(r8 & 255));
    checkOutput({tag, "_bo8"},   32'(bus8.bo),   32'((r8 >> 8) & 1));
    checkOutput({tag, "_ov8"},   32'(bus8.out_valid), 32'(v));
  endtask

  // Compare the combinational DUT with the reference for the vector currently applied
  task automatic checkComb(input string tag, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic c);
    int r;
    r = refSub(1, int'(a[0]), int'(b[0]), int'(c));
    checkOutput({tag, "_diffc"}, 32'(busc.diff), 32'(r & 1));
    checkOutput({tag, "_boc"},   32'(busc.bo),   32'((r >> 1) & 1));
    checkOutput({tag, "_ovc"},   32'(busc.out_valid), 32'(v));
  endtask

  // Main stimulus sequence
  initial begin
    logic [1:0] sweepTable [8];
    logic [7:0] ra, rb;
    logic       rc, rv;

    sweepTable = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h00, 8'h01, 1'b1);
    repeat (3) tick();
    checkOutput("rst_diff1", 32'(bus1.diff), 32'd0);
    checkOutput("rst_bo1",   32'(bus1.bo),   32'd0);
    checkOutput("rst_ov1",   32'(bus1.out_valid), 32'd0);
    checkOutput("rst_diff8", 32'(bus8.diff), 32'd0);
    checkOutput("rst_ov8",   32'(bus8.out_valid), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkRegistered("release", 1'b1, 8'h00, 8'h01, 1'b1);

    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      applyStimulus(1'b1, {7'd0, bits[2]}, {7'd0, bits[1]}, bits[0]);
      tick();
      checkRegistered("sweep", 1'b1, {7'd0, bits[2]}, {7'd0, bits[1]}, bits[0]);
      checkOutput("sweep_table", 32'({bus1.diff, bus1.bo}), 32'(sweepTable[v]));
    end

    applyStimulus(1'b1, 8'h00, 8'h01, 1'b0);
    tick();
    checkOutput("async_pre_bo1", 32'(bus1.bo), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_bo1",   32'(bus1.bo),   32'd0);
    checkOutput("async_ov1",   32'(bus1.out_valid), 32'd0);
    checkOutput("async_bo8",   32'(bus8.bo),   32'd0);
    checkOutput("async_ov8",   32'(bus8.out_valid), 32'd0);
    tick();
    checkOutput("async_hold_ov1", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h05, 8'h03, 1'b1);
    tick();
    checkRegistered("vpat1", 1'b1, 8'h05, 8'h03, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'hFF, 1'b1);
    tick();
    checkRegistered("vpat0", 1'b0, 8'h00, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'h80, 8'h80, 1'b0);
    tick();
    checkRegistered("vpat2", 1'b1, 8'h80, 8'h80, 1'b0);

    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b1);
    tick();
    checkOutput("wrap_diff8", 32'(bus8.diff), 32'h00);
    checkOutput("wrap_bo8",   32'(bus8.bo),   32'd1);

    applyStimulus(1'b0, 8'hxx, 8'hxx, 1'bx);
    tick();
    checkOutput("xin_ov1", 32'(bus1.out_valid), 32'd0);
    checkOutput("xin_ov8", 32'(bus8.out_valid), 32'd0);

    applyStimulus(1'b1, 8'h01, 8'h00, 1'b0);
    #1;
    checkOutput("comb_diff", 32'(busc.diff), 32'd1);
    checkOutput("comb_bo",   32'(busc.bo),   32'd0);
    checkOutput("comb_ov",   32'(busc.out_valid), 32'd1);
    tick();

    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rv = 1'($urandom);
      applyStimulus(rv, ra, rb, rc);
      #1;
      checkComb("rand", rv, ra, rb, rc);
      tick();
      checkRegistered("rand", rv, ra, rb, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
